// File: rtl/dram_port_arbiter.sv
// Round-robin N-port arbiter feeding one DRAM command slot, with a read-tag FIFO for response routing.
// Optional stall counter enabled by defining DRAM_ARB_PERF_STALL_EN.
module dram_port_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 128,
  parameter int MASK_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic [NUM_PORTS-1:0]            port_ren,
  input  logic [NUM_PORTS-1:0]            port_wen,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0] port_wmask,
  output logic [NUM_PORTS-1:0]            port_ready,
  output logic [DATA_WIDTH-1:0]           port_rdata,
  output logic [NUM_PORTS-1:0]            port_rvalid,
  output logic                            dram_ren,
  output logic                            dram_wen,
  output logic [ADDR_WIDTH-1:0]           dram_addr,
  output logic [DATA_WIDTH-1:0]           dram_wdata,
  output logic [MASK_WIDTH-1:0]           dram_wmask,
  input  logic                            dram_busy,
  input  logic [DATA_WIDTH-1:0]           dram_rdata,
  input  logic                            dram_rdata_valid,
  output logic                            err_orphan,
  output logic [31:0]                     perf_stall_cnt
);

  localparam int PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int FIFO_AW = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W   = FIFO_AW + 1;

  logic                  r_cmd_valid;
  logic                  r_cmd_wr;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [DATA_WIDTH-1:0] r_cmd_wdata;
  logic [MASK_WIDTH-1:0] r_cmd_wmask;
  logic [PTR_W-1:0]      r_ptr;

  logic [PTR_W-1:0]      r_tag_mem [MAX_OUTSTANDING];
  logic [FIFO_AW-1:0]    r_wr_ptr;
  logic [FIFO_AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [NUM_PORTS-1:0]  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_orphan;

  logic                  w_slot_free;
  logic                  w_full;
  logic [NUM_PORTS-1:0]  w_elig;
  logic                  w_hi_valid;
  logic [PTR_W-1:0]      w_hi_idx;
  logic                  w_lo_valid;
  logic [PTR_W-1:0]      w_lo_idx;
  logic                  w_grant_valid;
  logic [PTR_W-1:0]      w_grant_idx;
  logic                  w_grant_wr;
  logic                  w_push;
  logic                  w_pop;

  logic [ADDR_WIDTH-1:0] w_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_PORTS];
  logic [MASK_WIDTH-1:0] w_wmask [NUM_PORTS];

  assign w_slot_free = !r_cmd_valid || !dram_busy;
  assign w_full      = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_elig      = port_wen | (port_ren & {NUM_PORTS{!w_full}});

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_addr[i]  = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_wdata[i] = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      w_wmask[i] = port_wmask[i*MASK_WIDTH +: MASK_WIDTH];
    end
  end

  // Lowest eligible index at/after the pointer wins; otherwise wrap to the lowest eligible overall.
  always_comb begin
    w_hi_valid = 1'b0;
    w_hi_idx   = '0;
    w_lo_valid = 1'b0;
    w_lo_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_lo_valid = 1'b1;
        w_lo_idx   = PTR_W'(i);
        if (PTR_W'(i) >= r_ptr) begin
          w_hi_valid = 1'b1;
          w_hi_idx   = PTR_W'(i);
        end
      end
    end
  end

  assign w_grant_idx   = w_hi_valid ? w_hi_idx : w_lo_idx;
  assign w_grant_valid = w_lo_valid && w_slot_free && resetn;
  assign w_grant_wr    = port_wen[w_grant_idx];
  assign w_push        = w_grant_valid && !w_grant_wr;
  assign w_pop         = dram_rdata_valid && (r_count != '0);

  always_comb begin
    port_ready = '0;
    if (w_grant_valid) begin
      port_ready[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_cmd_valid <= 1'b0;
      r_cmd_wr    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_wmask <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_slot_free) begin
        r_cmd_valid <= w_grant_valid;
      end
      if (w_grant_valid) begin
        r_cmd_wr    <= w_grant_wr;
        r_cmd_addr  <= w_addr[w_grant_idx];
        r_cmd_wdata <= w_wdata[w_grant_idx];
        r_cmd_wmask <= w_wmask[w_grant_idx];
        if (w_grant_idx == PTR_W'(NUM_PORTS - 1)) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= w_grant_idx + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_grant_idx;
    end
  end

  // Responses come back in issue order, so the FIFO head always names the owner of the returning data.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_orphan <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_rvalid <= '0;
      if (w_pop) begin
        r_rvalid[r_tag_mem[r_rd_ptr]] <= 1'b1;
        r_rdata                       <= dram_rdata;
      end
      if (dram_rdata_valid && (r_count == '0)) begin
        r_orphan <= 1'b1;
      end
    end
  end

  assign dram_ren    = r_cmd_valid && !r_cmd_wr;
  assign dram_wen    = r_cmd_valid && r_cmd_wr;
  assign dram_addr   = r_cmd_addr;
  assign dram_wdata  = r_cmd_wdata;
  assign dram_wmask  = r_cmd_wmask;
  assign port_rvalid = r_rvalid;
  assign port_rdata  = r_rdata;
  assign err_orphan  = r_orphan;

`ifdef DRAM_ARB_PERF_STALL_EN
  logic [31:0] r_stall_cnt;

  // A stall is any cycle with a pending request that wins nothing; the count saturates.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if ((|(port_ren | port_wen)) && !w_grant_valid && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: vector table for steady-state behaviour plus
// hand-written sequences for outstanding-read limits, busy back-pressure, orphans and stall counting.
module tb_dram_port_arbiter;

  localparam int NP = 2;
  localparam int AW = 27;
  localparam int DW = 128;
  localparam int MW = 16;

  localparam logic [DW-1:0] D0  = {16{8'h11}};
  localparam logic [DW-1:0] D1  = {16{8'h22}};
  localparam logic [MW-1:0] M0  = 16'h000F;
  localparam logic [MW-1:0] M1  = 16'hF000;
  localparam logic [DW-1:0] A5  = {16{8'hA5}};
  localparam logic [DW-1:0] R77 = {16{8'h77}};

  logic              clock;
  logic              resetn;
  logic [NP-1:0]     port_ren;
  logic [NP-1:0]     port_wen;
  logic [AW-1:0]     addr0;
  logic [AW-1:0]     addr1;
  logic [NP*AW-1:0]  port_addr;
  logic [NP*DW-1:0]  port_wdata;
  logic [NP*MW-1:0]  port_wmask;
  logic [NP-1:0]     port_ready;
  logic [DW-1:0]     port_rdata;
  logic [NP-1:0]     port_rvalid;
  logic              dram_ren;
  logic              dram_wen;
  logic [AW-1:0]     dram_addr;
  logic [DW-1:0]     dram_wdata;
  logic [MW-1:0]     dram_wmask;
  logic              dram_busy;
  logic [DW-1:0]     dram_rdata;
  logic              dram_rdata_valid;
  logic              err_orphan;
  logic [31:0]       perf_stall_cnt;

  int totalChecks = 0;
  int badChecks   = 0;

  assign port_addr  = {addr1, addr0};
  assign port_wdata = {D1, D0};
  assign port_wmask = {M1, M0};

  dram_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .MAX_OUTSTANDING(4)
  ) dut (
    .clock(clock), .resetn(resetn),
    .port_ren(port_ren), .port_wen(port_wen), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_wmask(port_wmask),
    .port_ready(port_ready), .port_rdata(port_rdata), .port_rvalid(port_rvalid),
    .dram_ren(dram_ren), .dram_wen(dram_wen), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_wmask(dram_wmask), .dram_busy(dram_busy),
    .dram_rdata(dram_rdata), .dram_rdata_valid(dram_rdata_valid),
    .err_orphan(err_orphan), .perf_stall_cnt(perf_stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    ren;
    logic [1:0]    wen;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          busy;
    logic          rv;
    logic [DW-1:0] rd;
    logic [1:0]    expReady;
    logic          expRen;
    logic          expWen;
    logic [AW-1:0] expAddr;
    logic          expSrc;
    logic [1:0]    expRvalid;
    logic [DW-1:0] expRdata;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [1:0] ren, input logic [1:0] wen,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic rv, input logic [DW-1:0] rd,
                              input logic [1:0] eReady, input logic eRen, input logic eWen,
                              input logic [AW-1:0] eAddr, input logic eSrc,
                              input logic [1:0] eRvalid, input logic [DW-1:0] eRdata);
    vec_t v;
    v.ren = ren; v.wen = wen; v.a0 = a0; v.a1 = a1; v.busy = 1'b0; v.rv = rv; v.rd = rd;
    v.expReady = eReady; v.expRen = eRen; v.expWen = eWen; v.expAddr = eAddr;
    v.expSrc = eSrc; v.expRvalid = eRvalid; v.expRdata = eRdata;
    return v;
  endfunction

  function automatic logic [31:0] expStall(input int n);
`ifdef DRAM_ARB_PERF_STALL_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n - n);
`endif
  endfunction

  task automatic checkValue(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] ren, input logic [1:0] wen, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic busy, input logic rv, input logic [DW-1:0] rd);
    port_ren = ren; port_wen = wen; addr0 = a0; addr1 = a1;
    dram_busy = busy; dram_rdata_valid = rv; dram_rdata = rd;
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.ren, v.wen, v.a0, v.a1, v.busy, v.rv, v.rd);
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkValue({tag, " ready"}, DW'(port_ready), DW'(v.expReady));
    checkValue({tag, " dram_ren"}, DW'(dram_ren), DW'(v.expRen));
    checkValue({tag, " dram_wen"}, DW'(dram_wen), DW'(v.expWen));
    checkValue({tag, " rvalid"}, DW'(port_rvalid), DW'(v.expRvalid));
    if (v.expRen || v.expWen) begin
      checkValue({tag, " dram_addr"}, DW'(dram_addr), DW'(v.expAddr));
    end
    if (v.expWen) begin
      checkValue({tag, " dram_wdata"}, dram_wdata, v.expSrc ? D1 : D0);
      checkValue({tag, " dram_wmask"}, DW'(dram_wmask), DW'(v.expSrc ? M1 : M0));
    end
    if (v.expRvalid != 2'b00) begin
      checkValue({tag, " rdata"}, port_rdata, v.expRdata);
    end
    checkValue({tag, " stall_cnt"}, DW'(perf_stall_cnt), DW'(expStall(0)));
  endtask

  // Requests are held during reset to show that nothing can be granted then.
  task automatic doReset();
    resetn = 1'b0;
    drive(2'b00, 2'b11, 27'h100, 27'h200, 1'b0, 1'b0, '0);
    tick();
    checkValue("rst ready", DW'(port_ready), DW'(0));
    checkValue("rst dram_ren", DW'(dram_ren), DW'(0));
    checkValue("rst dram_wen", DW'(dram_wen), DW'(0));
    checkValue("rst rvalid", DW'(port_rvalid), DW'(0));
    checkValue("rst rdata", port_rdata, '0);
    checkValue("rst err_orphan", DW'(err_orphan), DW'(0));
    checkValue("rst stall_cnt", DW'(perf_stall_cnt), DW'(0));
    drive(2'b00, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    resetn = 1'b1;
  endtask

  task automatic busySeq(input int n);
    doReset();
    drive(2'b00, 2'b01, 27'h300, 27'h400, 1'b0, 1'b0, '0);
    checkValue("busy first grant", DW'(port_ready), DW'(2'b01));
    tick();
    for (int j = 0; j < n; j++) begin
      drive(2'b00, 2'b10, 27'h300, 27'h400, 1'b1, 1'b0, '0);
      checkValue($sformatf("busy%0d ready", j), DW'(port_ready), DW'(2'b00));
      checkValue($sformatf("busy%0d wen", j), DW'(dram_wen), DW'(1));
      checkValue($sformatf("busy%0d addr", j), DW'(dram_addr), DW'(27'h300));
      checkValue($sformatf("busy%0d wdata", j), dram_wdata, D0);
      tick();
    end
    drive(2'b00, 2'b10, 27'h300, 27'h400, 1'b0, 1'b0, '0);
    checkValue("busy release ready", DW'(port_ready), DW'(2'b10));
    checkValue("busy release addr", DW'(dram_addr), DW'(27'h300));
    tick();
    drive(2'b00, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    checkValue("busy next wen", DW'(dram_wen), DW'(1));
    checkValue("busy next addr", DW'(dram_addr), DW'(27'h400));
    checkValue("busy next wdata", dram_wdata, D1);
    checkValue($sformatf("stall_cnt after %0d", n), DW'(perf_stall_cnt), DW'(expStall(n)));
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    drive(2'b00, 2'b00, '0, '0, 1'b0, 1'b0, '0);

    vecs[0]  = mk(2'b00, 2'b11, 27'h100, 27'h200, 0, '0, 2'b01, 0, 0, '0,      0, 2'b00, '0);
    vecs[1]  = mk(2'b00, 2'b11, 27'h100, 27'h200, 0, '0, 2'b10, 0, 1, 27'h100, 0, 2'b00, '0);
    vecs[2]  = mk(2'b00, 2'b00, 27'h100, 27'h200, 0, '0, 2'b00, 0, 1, 27'h200, 1, 2'b00, '0);
    vecs[3]  = mk(2'b00, 2'b00, 27'h0,   27'h0,   0, '0, 2'b00, 0, 0, '0,      0, 2'b00, '0);
    vecs[4]  = mk(2'b10, 2'b00, 27'h0,   27'h40,  0, '0, 2'b10, 0, 0, '0,      0, 2'b00, '0);
    vecs[5]  = mk(2'b00, 2'b00, 27'h0,   27'h0,   0, '0, 2'b00, 1, 0, 27'h40,  0, 2'b00, '0);
    vecs[6]  = mk(2'b00, 2'b00, 27'h0,   27'h0,   0, '0, 2'b00, 0, 0, '0,      0, 2'b00, '0);
    vecs[7]  = mk(2'b00, 2'b00, 27'h0,   27'h0,   0, '0, 2'b00, 0, 0, '0,      0, 2'b00, '0);
    vecs[8]  = mk(2'b00, 2'b00, 27'h0,   27'h0,   1, A5, 2'b00, 0, 0, '0,      0, 2'b00, '0);
    vecs[9]  = mk(2'b00, 2'b00, 27'h0,   27'h0,   0, '0, 2'b00, 0, 0, '0,      0, 2'b10, A5);
    vecs[10] = mk(2'b00, 2'b00, 27'h0,   27'h0,   0, '0, 2'b00, 0, 0, '0,      0, 2'b00, '0);
    vecs[11] = mk(2'b01, 2'b01, 27'h55,  27'h0,   0, '0, 2'b01, 0, 0, '0,      0, 2'b00, '0);
    vecs[12] = mk(2'b00, 2'b00, 27'h0,   27'h0,   0, '0, 2'b00, 0, 1, 27'h55,  0, 2'b00, '0);
    vecs[13] = mk(2'b00, 2'b11, 27'h111, 27'h222, 0, '0, 2'b10, 0, 0, '0,      0, 2'b00, '0);
    vecs[14] = mk(2'b00, 2'b11, 27'h111, 27'h222, 0, '0, 2'b01, 0, 1, 27'h222, 1, 2'b00, '0);
    vecs[15] = mk(2'b00, 2'b00, 27'h0,   27'h0,   0, '0, 2'b00, 0, 1, 27'h111, 0, 2'b00, '0);

    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
      tick();
    end

    // Outstanding-read limit: four reads fill the tag FIFO, a write still gets through.
    doReset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 2'b00, 27'(27'h10 + i), 27'h0, 1'b0, 1'b0, '0);
      checkValue($sformatf("rd%0d ready", i), DW'(port_ready), DW'(2'b01));
      tick();
    end
    drive(2'b01, 2'b10, 27'h14, 27'h500, 1'b0, 1'b0, '0);
    checkValue("full: write ready", DW'(port_ready), DW'(2'b10));
    checkValue("full: last read cmd", DW'(dram_ren), DW'(1));
    checkValue("full: last read addr", DW'(dram_addr), DW'(27'h13));
    tick();
    drive(2'b01, 2'b00, 27'h14, 27'h0, 1'b0, 1'b1, R77);
    checkValue("full: read blocked", DW'(port_ready), DW'(2'b00));
    checkValue("full: write cmd addr", DW'(dram_addr), DW'(27'h500));
    checkValue("full: write cmd wen", DW'(dram_wen), DW'(1));
    tick();
    drive(2'b01, 2'b00, 27'h14, 27'h0, 1'b0, 1'b0, '0);
    checkValue("freed: read ready", DW'(port_ready), DW'(2'b01));
    checkValue("freed: rvalid", DW'(port_rvalid), DW'(2'b01));
    checkValue("freed: rdata", port_rdata, R77);
    tick();
    drive(2'b00, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    checkValue("freed: 5th read addr", DW'(dram_addr), DW'(27'h14));
    checkValue("freed: 5th read ren", DW'(dram_ren), DW'(1));
    tick();

    busySeq(5);
    busySeq(7);

    // Orphan read data with nothing outstanding, then sticky until reset.
    doReset();
    drive(2'b00, 2'b00, '0, '0, 1'b0, 1'b1, A5);
    tick();
    drive(2'b00, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    checkValue("orphan rvalid", DW'(port_rvalid), DW'(0));
    checkValue("orphan err", DW'(err_orphan), DW'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkValue($sformatf("orphan sticky%0d", i), DW'(err_orphan), DW'(1));
    end
    doReset();
    checkValue("orphan cleared", DW'(err_orphan), DW'(0));

    // Reset while a read is outstanding drops its tag.
    drive(2'b10, 2'b00, '0, 27'h60, 1'b0, 1'b0, '0);
    checkValue("midrst read ready", DW'(port_ready), DW'(2'b10));
    tick();
    doReset();
    drive(2'b00, 2'b00, '0, '0, 1'b0, 1'b1, A5);
    tick();
    drive(2'b00, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    checkValue("midrst rvalid", DW'(port_rvalid), DW'(0));
    checkValue("midrst err", DW'(err_orphan), DW'(1));
    tick();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
